// File: rtl/lcd_signal_gen.sv
// DMG-style LCD panel transmitter: turns a 2-bit pixel stream into cpg/cp/cpl/fr/st/s/ld panel signals.
// Every output is a flop; the h/v counters describe the line position that the next posedge drives.
module lcd_signal_gen #(
   parameter int H_ACTIVE    = 160,
   parameter int V_ACTIVE    = 144,
   parameter int V_TOTAL     = 154,
   parameter int LINE_CYCLES = 456,
   parameter int CPL_WIDTH   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pix_valid,
   input  logic [1:0] pix_data,
   output logic       pix_ready,
   output logic       cpg,
   output logic       cp,
   output logic       cpl,
   output logic       fr,
   output logic       st,
   output logic       s,
   output logic       ld0,
   output logic       ld1,
   output logic       underrun
);

   localparam int HW = $clog2(LINE_CYCLES);
   localparam int VW = $clog2(V_TOTAL);
   localparam int SW = $clog2(CPL_WIDTH + 1);

   localparam logic [HW-1:0] H_ZERO      = '0;
   localparam logic [HW-1:0] H_ONE       = HW'(1);
   localparam logic [HW-1:0] H_TWO       = HW'(2);
   localparam logic [HW-1:0] H_LAST      = HW'(LINE_CYCLES - 1);
   localparam logic [HW-1:0] H_CP_LAST   = HW'(2 * H_ACTIVE - 2);
   localparam logic [HW-1:0] H_RDY_LAST  = HW'(2 * H_ACTIVE - 1);
   localparam logic [HW-1:0] H_PIX_LAST  = HW'(2 * H_ACTIVE);
   localparam logic [HW-1:0] H_CPL_FIRST = HW'(2 * H_ACTIVE + 1);
   localparam logic [HW-1:0] H_CPL_LAST  = HW'(2 * H_ACTIVE + CPL_WIDTH);
   localparam logic [HW-1:0] H_FR        = HW'(2 * H_ACTIVE + CPL_WIDTH + 1);
   localparam logic [VW-1:0] V_ZERO      = '0;
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
   localparam logic [SW-1:0] SD_LAST     = SW'(CPL_WIDTH - 1);

   typedef enum logic [1:0] {ST_OFF, ST_ACTIVE, ST_SHUTDOWN} state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [SW-1:0] sd_cnt_q, sd_cnt_d;
   logic          cpg_q, cpg_d, cp_q, cp_d, cpl_q, cpl_d, fr_q, fr_d;
   logic          st_q, st_d, s_q, s_d, pix_ready_q, pix_ready_d;
   logic          underrun_q, underrun_d;
   logic [1:0]    ld_q, ld_d;
   logic          line_act;
   logic          pix_slot;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_OFF;
         h_q         <= '0;
         v_q         <= '0;
         sd_cnt_q    <= '0;
         cpg_q       <= 1'b0;
         cp_q        <= 1'b0;
         cpl_q       <= 1'b0;
         fr_q        <= 1'b0;
         st_q        <= 1'b0;
         s_q         <= 1'b0;
         pix_ready_q <= 1'b0;
         underrun_q  <= 1'b0;
         ld_q        <= 2'b00;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         sd_cnt_q    <= sd_cnt_d;
         cpg_q       <= cpg_d;
         cp_q        <= cp_d;
         cpl_q       <= cpl_d;
         fr_q        <= fr_d;
         st_q        <= st_d;
         s_q         <= s_d;
         pix_ready_q <= pix_ready_d;
         underrun_q  <= underrun_d;
         ld_q        <= ld_d;
      end
   end

   // Turn-on starts in the last (blank) line so the receiver sees one full latch before line 0.
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      v_d      = v_q;
      sd_cnt_d = '0;
      case (state_q)
         ST_OFF: begin
            h_d = '0;
            v_d = '0;
            if (enable) begin
               state_d = ST_ACTIVE;
               v_d     = V_LAST;
            end
         end
         ST_ACTIVE: begin
            if (!enable) begin
               state_d = ST_SHUTDOWN;
               h_d     = '0;
               v_d     = '0;
            end else if (h_q == H_LAST) begin
               h_d = '0;
               v_d = (v_q == V_LAST) ? V_ZERO : v_q + VW'(1);
            end else begin
               h_d = h_q + HW'(1);
            end
         end
         ST_SHUTDOWN: begin
            sd_cnt_d = sd_cnt_q + SW'(1);
            if (sd_cnt_q == SD_LAST) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

   assign line_act = (v_q < V_ACT);
   assign pix_slot = ~h_q[0] && (h_q >= H_TWO) && (h_q <= H_PIX_LAST);

   // A pixel whose handshake lands on the enable-drop edge is consumed but replaced by the off state.
   always_comb begin
      cpg_d       = 1'b0;
      cp_d        = 1'b0;
      cpl_d       = 1'b0;
      fr_d        = 1'b0;
      st_d        = 1'b0;
      s_d         = 1'b0;
      pix_ready_d = 1'b0;
      ld_d        = 2'b00;
      underrun_d  = underrun_q | (pix_ready_q & ~pix_valid);
      case (state_q)
         ST_ACTIVE: begin
            fr_d = fr_q;
            if (enable) begin
               cpg_d       = 1'b1;
               st_d        = (h_q <= H_ONE);
               cp_d        = (h_q == H_ZERO) || (~h_q[0] && (h_q >= H_TWO) && (h_q <= H_CP_LAST));
               cpl_d       = (h_q >= H_CPL_FIRST) && (h_q <= H_CPL_LAST);
               fr_d        = fr_q ^ (h_q == H_FR);
               s_d         = (v_q == V_ZERO);
               pix_ready_d = line_act && h_q[0] && (h_q <= H_RDY_LAST);
               if (!line_act)     ld_d = 2'b00;
               else if (pix_slot) ld_d = pix_valid ? pix_data : 2'b00;
               else               ld_d = ld_q;
            end
         end
         ST_SHUTDOWN: begin
            cpl_d = 1'b1;
            fr_d  = fr_q;
         end
         default: ;
      endcase
   end

   assign pix_ready = pix_ready_q;
   assign cpg       = cpg_q;
   assign cp        = cp_q;
   assign cpl       = cpl_q;
   assign fr        = fr_q;
   assign st        = st_q;
   assign s         = s_q;
   assign ld0       = ld_q[0];
   assign ld1       = ld_q[1];
   assign underrun  = underrun_q;

endmodule
